// File: rtl/processor_system_mem_fill_checker.sv
// Avalon-MM memory fill/check master: writes seed+address over a word range,
// reads it back through a fixed-latency pipeline and reports mismatches.
module processor_system_mem_fill_checker #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  check_only,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       length,
    input  logic [DATA_W-1:0]     seed,
    output logic [ADDR_W-1:0]     address,
    output logic [DATA_W/8-1:0]   byteenable,
    output logic                  chipselect,
    output logic                  write,
    output logic [DATA_W-1:0]     writedata,
    output logic                  clken,
    input  logic [DATA_W-1:0]     readdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_W:0]       error_count,
    output logic [ADDR_W-1:0]     first_err_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [ADDR_W-1:0]       r_base;
    logic [ADDR_W:0]         r_len;
    logic [DATA_W-1:0]       r_seed;
    logic [ADDR_W-1:0]       r_addr;
    logic [ADDR_W:0]         r_cnt;
    logic                    r_error;
    logic [ADDR_W:0]         r_err_cnt;
    logic [ADDR_W-1:0]       r_first_err;
    logic [READ_LATENCY-1:0] r_pipe_vld;
    logic [ADDR_W-1:0]       r_pipe_addr [READ_LATENCY];

    logic                    w_last;
    logic                    w_accept;
    logic                    w_issue_rd;
    logic                    w_tail_vld;
    logic [ADDR_W-1:0]       w_tail_addr;
    logic [DATA_W-1:0]       w_expected;
    logic                    w_mismatch;

    assign w_last      = (r_cnt == (ADDR_W+1)'(1));
    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_issue_rd  = (r_state == S_READ);
    assign w_tail_vld  = r_pipe_vld[READ_LATENCY-1];
    assign w_tail_addr = r_pipe_addr[READ_LATENCY-1];
    assign w_expected  = r_seed + DATA_W'(w_tail_addr);
    assign w_mismatch  = w_tail_vld && (readdata != w_expected);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: next state gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (length == '0)    w_next_state = S_FINISH;
                    else if (check_only) w_next_state = S_READ;
                    else                 w_next_state = S_WRITE;
                end
            end
            S_WRITE:  if (w_last) w_next_state = S_READ;
            S_READ:   if (w_last) w_next_state = S_DRAIN;
            S_DRAIN:  if (w_last) w_next_state = S_FINISH;
            S_FINISH: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Address walk and pass counters; the range wraps naturally in ADDR_W bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_base <= '0;
            r_len  <= '0;
            r_seed <= '0;
            r_addr <= '0;
            r_cnt  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base <= base_addr;
                        r_len  <= length;
                        r_seed <= seed;
                        r_addr <= base_addr;
                        r_cnt  <= length;
                    end
                end
                S_WRITE: begin
                    if (w_last) begin
                        r_addr <= r_base;
                        r_cnt  <= r_len;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                        r_cnt  <= r_cnt - 1'b1;
                    end
                end
                S_READ: begin
                    if (w_last) begin
                        r_cnt <= (ADDR_W+1)'(READ_LATENCY);
                    end else begin
                        r_addr <= r_addr + 1'b1;
                        r_cnt  <= r_cnt - 1'b1;
                    end
                end
                S_DRAIN: r_cnt <= r_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe_vld <= '0;
        end else begin
            r_pipe_vld[0] <= w_issue_rd;
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_pipe_vld[k] <= r_pipe_vld[k-1];
            end
        end
    end

    // NOTE: only the valid bits need reset; the address stages are qualified
    // by them, so leaving this storage unreset is safe and cheaper.
    always_ff @(posedge clk) begin
        r_pipe_addr[0] <= r_addr;
        for (int k = 1; k < READ_LATENCY; k++) begin
            r_pipe_addr[k] <= r_pipe_addr[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_error     <= 1'b0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
        end else if (w_accept) begin
            r_error     <= 1'b0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
        end else if (w_mismatch) begin
            r_error   <= 1'b1;
            r_err_cnt <= r_err_cnt + 1'b1;
            if (!r_error) begin
                r_first_err <= w_tail_addr;
            end
        end
    end

    assign address        = r_addr;
    assign byteenable     = '1;
    assign clken          = 1'b1;
    assign chipselect     = (r_state == S_WRITE) || (r_state == S_READ);
    assign write          = (r_state == S_WRITE);
    assign writedata      = r_seed + DATA_W'(r_addr);
    assign busy           = (r_state == S_WRITE) || (r_state == S_READ) || (r_state == S_DRAIN);
    assign done           = (r_state == S_FINISH);
    assign error          = r_error;
    assign error_count    = r_err_cnt;
    assign first_err_addr = r_first_err;

endmodule

// File: tb/tb_processor_system_mem_fill_checker.sv
// Directed bench: two checker instances (read latency 1 and 2), each with a
// behavioural on-chip memory; cycle numbers count from the start-accept cycle.
module tb_processor_system_mem_fill_checker;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    typedef struct {
        int          cyc;
        bit          wr;
        logic [9:0]  addr;
        logic [31:0] data;
    } acc_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        reset, start, start2, check_only;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic [31:0] seed;
    bit          stuck_en;

    logic [9:0]  addr1, addr2, fea1, fea2;
    logic [3:0]  be1, be2;
    logic        cs1, cs2, wr1, wr2, ck1, ck2, busy1, busy2, done1, done2, err1, err2;
    logic [31:0] wd1, wd2, rd1, rd2, rd2_q;
    logic [10:0] ec1, ec2;
    logic [31:0] mem1 [1024];
    logic [31:0] mem2 [1024];

    processor_system_mem_fill_checker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .check_only(check_only),
        .base_addr(base_addr), .length(length), .seed(seed),
        .address(addr1), .byteenable(be1), .chipselect(cs1), .write(wr1),
        .writedata(wd1), .clken(ck1), .readdata(rd1), .busy(busy1), .done(done1),
        .error(err1), .error_count(ec1), .first_err_addr(fea1)
    );

    processor_system_mem_fill_checker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .check_only(check_only),
        .base_addr(base_addr), .length(length), .seed(seed),
        .address(addr2), .byteenable(be2), .chipselect(cs2), .write(wr2),
        .writedata(wd2), .clken(ck2), .readdata(rd2), .busy(busy2), .done(done2),
        .error(err2), .error_count(ec2), .first_err_addr(fea2)
    );

    // Memory models; word 0x005 of the first one can have bit 3 stuck at 0.
    always @(posedge clk) begin
        if (cs1 && wr1) mem1[addr1] <= wd1;
        rd1 <= mem1[addr1] & ~((stuck_en && addr1 == 10'h005) ? 32'h8 : 32'h0);
        if (cs2 && wr2) mem2[addr2] <= wd2;
        rd2_q <= mem2[addr2];
        rd2   <= rd2_q;
    end

    bit sel;
    wire        m_cs   = sel ? cs2   : cs1;
    wire        m_wr   = sel ? wr2   : wr1;
    wire [9:0]  m_addr = sel ? addr2 : addr1;
    wire [31:0] m_wd   = sel ? wd2   : wd1;
    wire        m_busy = sel ? busy2 : busy1;
    wire        m_done = sel ? done2 : done1;
    wire        m_err  = sel ? err2  : err1;
    wire [10:0] m_ec   = sel ? ec2   : ec1;
    wire [9:0]  m_fea  = sel ? fea2  : fea1;

    int   n_checks = 0;
    int   n_pass   = 0;
    acc_t acc_log[$];
    int   done_cyc, n_done, n_wr, n_rd;
    logic busy_after, cs_after;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Launches one operation and logs bus traffic until 4 cycles after done.
    // A second start is pulsed in cycles rs1/rs2 (use -1 for none).
    task automatic run_op(input bit s, input logic [9:0] b, input logic [10:0] l,
                          input logic [31:0] sd, input logic co,
                          input int rs1, input int rs2, input int max_cyc);
        int t0;
        int c;
        sel = s;
        acc_log.delete();
        done_cyc = -1; n_done = 0; n_wr = 0; n_rd = 0;
        busy_after = 1'bx; cs_after = 1'bx;
        @(negedge clk);
        base_addr = b; length = l; seed = sd; check_only = co;
        if (s) start2 = 1'b1; else start = 1'b1;
        t0 = cyc;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            start = 1'b0; start2 = 1'b0;
            c = cyc - t0;
            if (c == rs1 || c == rs2) begin
                length = 11'd3; check_only = 1'b1;
                if (s) start2 = 1'b1; else start = 1'b1;
            end
            if (m_cs) begin
                acc_log.push_back('{c, m_wr, m_addr, m_wd});
                if (m_wr) n_wr++; else n_rd++;
            end
            if (m_done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                busy_after = m_busy;
                cs_after   = m_cs;
            end
            if (done_cyc >= 0 && c >= done_cyc + 4) break;
        end
        start = 1'b0; start2 = 1'b0;
        check("done_seen", done_cyc >= 0, 1);
    endtask

    logic [9:0] wrap_exp [4];
    int bad;

    initial begin
        reset = 1'b1; start = 1'b0; start2 = 1'b0; check_only = 1'b0;
        base_addr = '0; length = '0; seed = '0; stuck_en = 1'b0; sel = 1'b0;
        wrap_exp[0] = 10'h3FE; wrap_exp[1] = 10'h3FF; wrap_exp[2] = 10'h000; wrap_exp[3] = 10'h001;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_chipselect", cs1, 0);
        check("rst_write", wr1, 0);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_error", err1, 0);
        check("rst_error_count", ec1, 0);
        check("rst_first_err_addr", fea1, 0);
        check("rst_address", addr1, 0);
        check("rst_writedata", wd1, 0);
        check("rst_byteenable", be1, 4'hF);
        check("rst_clken", ck1, 1);
        check("rst_byteenable2", be2, 4'hF);
        check("rst_clken2", ck2, 1);

        // Clean fill/check
        run_op(0, 10'h000, 11'd16, 32'hA5A5_0000, 0, -1, -1, 200);
        check("clean_done_cyc", done_cyc, 34);
        check("clean_n_wr", n_wr, 16);
        check("clean_n_rd", n_rd, 16);
        check("clean_error", m_err, 0);
        check("clean_error_count", m_ec, 0);
        check("clean_first_wr_cyc", acc_log[0].cyc, 1);
        check("clean_first_rd_cyc", acc_log[16].cyc, 17);
        check("clean_first_wd", acc_log[0].data, 32'hA5A5_0000);
        check("clean_last_wd", acc_log[15].data, 32'hA5A5_000F);
        bad = 0;
        foreach (acc_log[i]) begin
            if (acc_log[i].addr != 10'(i % 16) || acc_log[i].wr != (i < 16)) bad++;
            if (i < 16 && acc_log[i].data != 32'hA5A5_0000 + 32'(i)) bad++;
        end
        check("clean_sequence_bad", bad, 0);

        // Wrap-around past the top word
        run_op(0, 10'h3FE, 11'd4, 32'h1234_5678, 0, -1, -1, 100);
        check("wrap_n_acc", acc_log.size(), 8);
        foreach (acc_log[i]) check($sformatf("wrap_addr%0d", i), acc_log[i].addr, wrap_exp[i % 4]);
        check("wrap_wd_3ff", acc_log[1].data, 32'h1234_5678 + 32'h3FF);
        check("wrap_error_count", m_ec, 0);

        // Stuck bit at word 0x005; seed 8 makes pat(5)=0xD so bit 3 is set
        stuck_en = 1'b1;
        run_op(0, 10'h000, 11'd8, 32'h0000_0008, 0, -1, -1, 100);
        stuck_en = 1'b0;
        check("fault_error", m_err, 1);
        check("fault_error_count", m_ec, 1);
        check("fault_first_err_addr", m_fea, 10'h005);

        // Fill with seed 0, then check-only with seed 1: every word mismatches
        run_op(0, 10'h100, 11'd8, 32'h0, 0, -1, -1, 100);
        check("fill_error_count", m_ec, 0);
        run_op(0, 10'h100, 11'd8, 32'h1, 1, -1, -1, 100);
        check("chk_n_wr", n_wr, 0);
        check("chk_n_rd", n_rd, 8);
        check("chk_first_rd_cyc", acc_log[0].cyc, 1);
        check("chk_done_cyc", done_cyc, 10);
        check("chk_error", m_err, 1);
        check("chk_error_count", m_ec, 8);
        check("chk_first_err_addr", m_fea, 10'h100);

        // length=0: immediate done, status cleared
        run_op(0, 10'h020, 11'd0, 32'h5, 0, -1, -1, 20);
        check("len0_done_cyc", done_cyc, 1);
        check("len0_n_acc", acc_log.size(), 0);
        check("len0_error", m_err, 0);
        check("len0_error_count", m_ec, 0);

        // Starts during WRITE (cycle 5) and during FINISH (cycle 34) are ignored
        run_op(0, 10'h040, 11'd16, 32'hCAFE_0000, 0, 5, 34, 200);
        check("busy_done_cyc", done_cyc, 34);
        check("busy_n_done", n_done, 1);
        check("busy_n_wr", n_wr, 16);
        check("busy_n_rd", n_rd, 16);
        check("busy_after_finish", busy_after, 0);
        check("cs_after_finish", cs_after, 0);

        // Reset in cycle 5 of a write pass
        begin
            int t0;
            int dn;
            sel = 1'b0;
            @(negedge clk);
            base_addr = 10'h000; length = 11'd16; seed = 32'h0; check_only = 1'b0; start = 1'b1;
            t0 = cyc;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                start = 1'b0;
            end
            check("rstmid_in_write", wr1 && (cyc - t0 == 5), 1);
            reset = 1'b1;
            @(negedge clk);
            check("rstmid_chipselect", cs1, 0);
            check("rstmid_busy", busy1, 0);
            check("rstmid_error_count", ec1, 0);
            check("rstmid_done", done1, 0);
            reset = 1'b0;
            dn = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done1) dn++;
            end
            check("rstmid_no_done", dn, 0);
        end
        run_op(0, 10'h010, 11'd4, 32'h7, 0, -1, -1, 50);
        check("postrst_done_cyc", done_cyc, 10);
        check("postrst_n_wr", n_wr, 4);
        check("postrst_error_count", m_ec, 0);

        // Full-depth run, read latency 2
        run_op(1, 10'h000, 11'd1024, 32'hDEAD_0000, 0, -1, -1, 3000);
        check("full_done_cyc", done_cyc, 2051);
        check("full_n_wr", n_wr, 1024);
        check("full_n_rd", n_rd, 1024);
        check("full_error", m_err, 0);
        check("full_error_count", m_ec, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
